// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: state encoding,
// instruction decode constants and default exception/writeback codes.
package muldiv_pkg;

   // Sequencer state encoding (kept as plain constants for legacy tools).
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;
   localparam logic [1:0] ST_WB    = 2'd3;

   // Instruction decode constants.
   localparam logic [4:0] R_TYPE  = 5'b00000;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   // Default exception register and codes.
   localparam int RSTATUS_DEFAULT  = 30;
   localparam int MUL_EXC_DEFAULT  = 4;
   localparam int DIV_EXC_DEFAULT  = 5;

   // Mul and div share every ALUop bit except bit 0, which selects divide.
   function automatic logic is_md_instr(input logic       valid,
                                        input logic [4:0] opc,
                                        input logic [4:0] aluop);
      return valid && (opc == R_TYPE) && (aluop[4:1] == ALU_MUL[4:1]);
   endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating BUSY-cycle counter with synchronous clear and a terminal-count
// flag; it stops at TERMINAL so the sequencer's forced exit never sees a wrap.
module md_timeout_counter #(
   parameter int CNT_W    = 6,
   parameter int TERMINAL = 39
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins over enable, and counting halts at the terminal value.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != TC_VAL)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
         count_q <= count_d;
      end
   end

   assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multicycle sequencer for the shared multiply/divide unit: stalls the
// pipeline on a mul/div, pulses the unit's start, waits for ready (or times
// out), then performs one register-file writeback of result or error code.
module muldiv_seq_ctrl
   import muldiv_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int TIMEOUT      = 40,
   parameter int CNT_W        = 6,
   parameter int RSTATUS_ADDR = RSTATUS_DEFAULT,
   parameter int MUL_EXC_CODE = MUL_EXC_DEFAULT,
   parameter int DIV_EXC_CODE = DIV_EXC_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [4:0]        opcode,
   input  logic [4:0]        ALUop,
   input  logic [4:0]        rd,
   input  logic              instr_valid,
   input  logic              flush,
   input  logic              md_ready,
   input  logic              md_exception,
   input  logic [DATA_W-1:0] md_result,
   output logic              ctrl_mult,
   output logic              ctrl_div,
   output logic              stall,
   output logic              wb_en,
   output logic [4:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              busy
);

   logic [1:0]        state_q,   state_d;
   logic              op_div_q,  op_div_d;
   logic [4:0]        rd_q,      rd_d;
   logic              exc_q,     exc_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic is_md;
   logic cnt_clr;
   logic cnt_en;
   logic cnt_tc;

   assign is_md = is_md_instr(instr_valid, opcode, ALUop);

   md_timeout_counter #(
      .CNT_W    (CNT_W),
      .TERMINAL (TIMEOUT - 1)
   ) u_timeout (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .tc      (cnt_tc)
   );

   // Sequencer next-state, operand capture and writeback value selection.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d   = state_q;
      op_div_d  = op_div_q;
      rd_d      = rd_q;
      exc_d     = exc_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (is_md && !flush) begin
               state_d  = ST_START;
               op_div_d = ALUop[0];
               rd_d     = rd;
            end
         end
         ST_START: begin
            cnt_clr = 1'b1;
            state_d = flush ? ST_IDLE : ST_BUSY;
         end
         ST_BUSY: begin
            cnt_en = 1'b1;
            if (flush) begin
               state_d = ST_IDLE;
            end else if (md_ready || cnt_tc) begin
               // A ready in the timeout cycle still wins and supplies the flag.
               state_d = ST_WB;
               exc_d   = md_ready ? md_exception : 1'b1;
            end
         end
         ST_WB: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Writeback address/data load only on entry to WB, and hold otherwise.
      if ((state_q == ST_BUSY) && (state_d == ST_WB)) begin
         if (exc_d) begin
            wb_addr_d = 5'(RSTATUS_ADDR);
            wb_data_d = op_div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MUL_EXC_CODE);
         end else begin
            wb_addr_d = rd_q;
            wb_data_d = md_result;
         end
      end
   end

   // Sequencer state and captured operation registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         op_div_q  <= 1'b0;
         rd_q      <= '0;
         exc_q     <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_div_q  <= op_div_d;
         rd_q      <= rd_d;
         exc_q     <= exc_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   // Outputs decoded from registered state; the IDLE stall term is combinational
   // so the mul/div holds in the very cycle it is first seen.
   assign ctrl_mult = (state_q == ST_START) && !op_div_q;
   assign ctrl_div  = (state_q == ST_START) &&  op_div_q;
   assign stall     = ((state_q == ST_IDLE) && is_md) ||
                      (state_q == ST_START) || (state_q == ST_BUSY);
   assign busy      = (state_q != ST_IDLE);
   assign wb_en     = (state_q == ST_WB) && (exc_q || (rd_q != 5'd0));
   assign wb_addr   = wb_addr_q;
   assign wb_data   = wb_data_q;

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Multicycle sequencer for the shared multiply/divide unit in the single-cycle processor.
- Detects R-type mul/div instructions (opcode 00000 with ALUop 00110 or 00111) and freezes the pipeline via `stall`.
- Issues one start pulse to the multdiv unit and waits for its ready/exception handshake.
- Produces one register-file writeback: the result to $rd, or an error code to $rstatus.

Parameters:
- DATA_W, 32, datapath and result width
- TIMEOUT, 40, max BUSY cycles before a timeout exception; must be ≥2
- CNT_W, 6, counter width; must satisfy 2^CNT_W > TIMEOUT
- RSTATUS_ADDR, 30, register written on exception
- MUL_EXC_CODE, 4, value written for a mul exception or mul timeout
- DIV_EXC_CODE, 5, value written for a div exception or div timeout

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  5  current instruction opcode
- ALUop  in  5  current instruction ALU op field
- rd  in  5  destination register of the current instruction
- instr_valid  in  1  current instruction is valid (not a bubble)
- flush  in  1  abort any in-flight op (interrupt/redirect)
- md_ready  in  1  multdiv result valid, single-cycle pulse
- md_exception  in  1  multdiv exception, qualified by md_ready
- md_result  in  DATA_W  multdiv result, qualified by md_ready
- ctrl_mult  out  1  single-cycle start pulse for a multiply
- ctrl_div  out  1  single-cycle start pulse for a divide
- stall  out  1  hold PC and freeze pipeline state
- wb_en  out  1  register-file write enable for this op
- wb_addr  out  5  writeback register address
- wb_data  out  DATA_W  writeback data
- busy  out  1  sequencer not in IDLE

Behaviour:
- Clock and reset: single clock `clock`; `reset_n` is asynchronous and active-low.
- Reset: state=IDLE; count, op/rd/result/exception registers cleared. Outputs: ctrl_mult=0, ctrl_div=0, wb_en=0, wb_addr=0, wb_data=0, busy=0. stall=0 unless the combinational IDLE detect term applies (see IDLE).
- Reset mid-operation returns to IDLE immediately. No pulse and no writeback is produced afterwards.
- Decode: is_md = instr_valid & opcode==00000 & ALUop[4:1]==0011. is_div = ALUop[0].
- States: IDLE, START, BUSY, WB.
- IDLE:
  - stall = is_md (combinational), so the instruction holds in the same cycle it is first seen.
  - On is_md & !flush: latch rd and op, then go to START.
  - flush has priority over detection.
- START:
  - Exactly one of ctrl_mult/ctrl_div =1 (registered from the state and latched op); stall=1; count←0.
  - md_ready in this cycle is ignored.
  - Next state: BUSY, or IDLE if flush.
- BUSY:
  - stall=1; count←count+1.
  - Priority order: flush → IDLE, no writeback, result discarded. Else md_ready → latch md_result and md_exception, go to WB. Else count==TIMEOUT-1 → set exception, go to WB.
  - md_ready and the timeout in the same cycle: md_ready wins, and its exception flag is used.
- WB:
  - stall=0, so the held instruction retires this cycle.
  - wb_en=1 for exactly one cycle.
  - If exception: wb_addr=RSTATUS_ADDR, wb_data=MUL_EXC_CODE or DIV_EXC_CODE (zero-extended).
  - Else: wb_addr=latched rd, wb_data=latched result. If rd==0, wb_en=0 ($0 is never written).
  - flush in WB is ignored (the op has completed). instr_valid is ignored (it is the retiring instruction).
  - Next state: IDLE.
- Outside WB: wb_en=0; wb_addr and wb_data hold their last values.
- Back-to-back mul/div: the second one is detected in the IDLE cycle after WB, giving a minimum 4-cycle occupancy per op plus unit latency.
- Latency: start pulse 1 cycle after detect. Writeback 1 cycle after md_ready.
- busy = (state != IDLE).
- Counter never wraps: it saturates at TIMEOUT-1, and its exit is forced.

Decomposition:
- Shared package muldiv_pkg holds:
  - state encoding (IDLE=2'd0, START=2'd1, BUSY=2'd2, WB=2'd3)
  - opcode constant R_TYPE=5'b00000
  - ALUop constants ALU_MUL=5'b00110, ALU_DIV=5'b00111
  - exception-code and RSTATUS constants
- One natural sub-module: md_timeout_counter, a clear/enable/terminal-count counter of CNT_W bits.

Test Plan:
- Mul success: opcode 00000, ALUop 00110, rd=7, instr_valid=1 → stall=1 the same cycle; ctrl_mult=1 in exactly the next cycle. Then md_ready=1 with md_result=0x0000_0015 after 5 BUSY cycles → next cycle wb_en=1, wb_addr=7, wb_data=0x15, stall=0; IDLE after.
- Div exception: ALUop 00111, rd=3 → ctrl_div pulse; md_ready=1 with md_exception=1 → wb_addr=30, wb_data=5, no write to r3.
- Timeout: mul issued, md_ready never asserted → after TIMEOUT=40 BUSY cycles, wb_addr=30, wb_data=4; stall spans detect cycle through the last BUSY cycle.
- Flush: div issued, flush=1 in the 3rd BUSY cycle → next cycle IDLE, stall=0, wb_en never asserted; a later md_ready is ignored.
- rd=0 and non-md instruction: mul to r0 completes with wb_en=0. add (opcode 00000, ALUop 00000) → no stall, no pulse. Back-to-back mul,mul → second ctrl_mult fires 2 cycles after the first WB.
- Async reset: assert reset_n=0 mid-BUSY, off-edge → state IDLE, busy=0, ctrl_*=0 immediately; no writeback after release.
